// File: rtl/sobel_window_core.sv
// Sobel gradient-magnitude stage fed by a 3x3 window stream: three pipeline stages,
// raster position tracking for border blanking, and line/frame-end tagging.
module sobel_window_core #(
    parameter int          IMG_W  = 640,
    parameter int          IMG_H  = 480,
    parameter logic [7:0]  THRESH = 8'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iValid,
    input  logic       iSof,
    input  logic [7:0] iData_11,
    input  logic [7:0] iData_12,
    input  logic [7:0] iData_13,
    input  logic [7:0] iData_21,
    input  logic [7:0] iData_22,
    input  logic [7:0] iData_23,
    input  logic [7:0] iData_31,
    input  logic [7:0] iData_32,
    input  logic [7:0] iData_33,
    output logic       oValid,
    output logic [7:0] oData,
    output logic       oEdge,
    output logic       oEol,
    output logic       oEof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          beat_mask, beat_eol, beat_eof;

    logic [9:0] px_q, px_d, nx_q, nx_d, py_q, py_d, ny_q, ny_d;
    logic [9:0] gx_q, gx_d, gy_q, gy_d;
    logic [1:0] vld_q, vld_d, mask_q, mask_d, eol_q, eol_d, eof_q, eof_d;

    logic       ovalid_q, ovalid_d, oedge_q, oedge_d, oeol_q, oeol_d, oeof_q, oeof_d;
    logic [7:0] odata_q, odata_d;
    logic [10:0] mag;
    logic [7:0]  mag_sat;
    logic        keep;

    // Position of the current beat; a start-of-frame beat is always (0,0).
    always_comb begin
        cur_col = iSof ? '0 : col_q;
        cur_row = iSof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (iValid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
        beat_mask = (cur_col < CW'(2)) || (cur_row < RW'(2));
        beat_eol  = (cur_col == LAST_COL);
        beat_eof  = beat_eol && (cur_row == LAST_ROW);
    end

    always_comb begin
        px_d = {2'b00, iData_13} + {1'b0, iData_23, 1'b0} + {2'b00, iData_33};
        nx_d = {2'b00, iData_11} + {1'b0, iData_21, 1'b0} + {2'b00, iData_31};
        py_d = {2'b00, iData_31} + {1'b0, iData_32, 1'b0} + {2'b00, iData_33};
        ny_d = {2'b00, iData_11} + {1'b0, iData_12, 1'b0} + {2'b00, iData_13};

        gx_d = (px_q >= nx_q) ? (px_q - nx_q) : (nx_q - px_q);
        gy_d = (py_q >= ny_q) ? (py_q - ny_q) : (ny_q - py_q);

        vld_d  = {vld_q[0],  iValid};
        mask_d = {mask_q[0], beat_mask};
        eol_d  = {eol_q[0],  beat_eol};
        eof_d  = {eof_q[0],  beat_eof};

        mag      = {1'b0, gx_q} + {1'b0, gy_q};
        mag_sat  = (mag > 11'd255) ? 8'hFF : mag[7:0];
        keep     = vld_q[1] && !mask_q[1];
        odata_d  = keep ? mag_sat : 8'h00;
        oedge_d  = keep && (mag_sat > THRESH);
        ovalid_d = vld_q[1];
        oeol_d   = vld_q[1] && eol_q[1];
        oeof_d   = vld_q[1] && eof_q[1];
    end

    // Data registers reset too, so a reset flushes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            px_q     <= '0;
            nx_q     <= '0;
            py_q     <= '0;
            ny_q     <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            vld_q    <= '0;
            mask_q   <= '0;
            eol_q    <= '0;
            eof_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            oedge_q  <= 1'b0;
            oeol_q   <= 1'b0;
            oeof_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            px_q     <= px_d;
            nx_q     <= nx_d;
            py_q     <= py_d;
            ny_q     <= ny_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            vld_q    <= vld_d;
            mask_q   <= mask_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            oedge_q  <= oedge_d;
            oeol_q   <= oeol_d;
            oeof_q   <= oeof_d;
        end
    end

    assign oValid = ovalid_q;
    assign oData  = odata_q;
    assign oEdge  = oedge_q;
    assign oEol   = oeol_q;
    assign oEof   = oeof_q;

endmodule
